// File: rtl/sink_pkg.sv
// Shared constants and types for the stream sink checker.
// LFSR geometry, monitor states and ready-threshold width.
package sink_pkg;

    localparam int LFSR_W   = 16;
    localparam int THRESH_W = 9;

    localparam int TAP_A = 16;
    localparam int TAP_B = 14;
    localparam int TAP_C = 13;
    localparam int TAP_D = 11;

    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [0:0] {
        MON_IDLE    = 1'b0,
        MON_PENDING = 1'b1
    } mon_state_e;

    // Fibonacci shift right; tap n maps to bit (16 - n)
    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s
    );
        logic fb;
        fb = s[LFSR_W-TAP_A] ^ s[LFSR_W-TAP_B]
           ^ s[LFSR_W-TAP_C] ^ s[LFSR_W-TAP_D];
        return {fb, s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/stream_sink_checker_if.sv
// VALID/READY stream between source and sink.
// Member names follow the sink-side port naming.
interface stream_sink_checker_if #(
    parameter int WIDTH = 9
);

    logic             i_VALID;
    logic [WIDTH-1:0] i_DATA;
    logic             o_READY;

    modport master (
        output i_VALID,
        output i_DATA,
        input  o_READY
    );

    modport slave (
        input  i_VALID,
        input  i_DATA,
        output o_READY
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16/14/13/11.
// A zero seed is replaced by 1 so the register cannot lock up.
module lfsr16
    import sink_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] o_state
);

    localparam logic [LFSR_W-1:0] SEED_EFF =
        (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = lfsr_next(state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED_EFF;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/stream_sink_checker.sv
// Stream sink with LFSR backpressure, accept count and running sum.
// Define SINK_PROTO_CHECK_EN to build the drop/data-change monitor.
module stream_sink_checker
    import sink_pkg::*;
#(
    parameter int                WIDTH        = 9,
    parameter int                CNT_WIDTH    = 16,
    parameter int                SUM_WIDTH    = 16,
    parameter int                READY_THRESH = 128,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_SEED_DEF
) (
    input  logic                 i_CLK,
    input  logic                 i_RSTn,
    input  logic                 i_EN,
    input  logic                 i_CLR,
    stream_sink_checker_if.slave s_if,
    output logic                 o_ACCEPT,
    output logic [WIDTH-1:0]     o_LAST_DATA,
    output logic [CNT_WIDTH-1:0] o_COUNT,
    output logic [SUM_WIDTH-1:0] o_SUM,
    output logic                 o_ERR_DROP,
    output logic                 o_ERR_DATA
);

    localparam logic [THRESH_W-1:0] THR =
        THRESH_W'(READY_THRESH);

    logic [LFSR_W-1:0] lfsr_w;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (i_CLK),
        .rst_n   (i_RSTn),
        .o_state (lfsr_w)
    );

    logic             valid;
    logic [WIDTH-1:0] data;
    logic             hs;

    assign valid = s_if.i_VALID;
    assign data  = s_if.i_DATA;

    logic                 ready_q, ready_d;
    logic                 acc_q, acc_d;
    logic [WIDTH-1:0]     last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;

    // Clear first, then fold in a same-edge handshake
    always_comb begin
        hs      = valid && ready_q;
        acc_d   = hs;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        last_d  = last_q;
        ready_d = i_EN
               && ({1'b0, lfsr_w[7:0]} < THR)
               && (lfsr_w != '0);
        if (i_CLR) begin
            cnt_d  = '0;
            sum_d  = '0;
            last_d = '0;
        end
        if (hs) begin
            cnt_d  = cnt_d + CNT_WIDTH'(1);
            sum_d  = sum_d + SUM_WIDTH'(data);
            last_d = data;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            ready_q <= 1'b0;
            acc_q   <= 1'b0;
            last_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            ready_q <= ready_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    assign s_if.o_READY = ready_q;
    assign o_ACCEPT     = acc_q;
    assign o_LAST_DATA  = last_q;
    assign o_COUNT      = cnt_q;
    assign o_SUM        = sum_q;

`ifdef SINK_PROTO_CHECK_EN

    mon_state_e       st_q, st_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic             drop_q, drop_d;
    logic             derr_q, derr_d;

    always_comb begin
        st_d   = st_q;
        snap_d = snap_q;
        drop_d = drop_q;
        derr_d = derr_q;
        unique case (st_q)
            MON_IDLE: begin
                if (valid && !ready_q) begin
                    st_d   = MON_PENDING;
                    snap_d = data;
                end
            end
            MON_PENDING: begin
                if (!valid) begin
                    drop_d = 1'b1;
                    st_d   = MON_IDLE;
                end else begin
                    if (data != snap_q) begin
                        derr_d = 1'b1;
                        snap_d = data;
                    end
                    if (ready_q) begin
                        st_d = MON_IDLE;
                    end
                end
            end
        endcase
        if (i_CLR) begin
            drop_d = 1'b0;
            derr_d = 1'b0;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            st_q   <= MON_IDLE;
            snap_q <= '0;
            drop_q <= 1'b0;
            derr_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            snap_q <= snap_d;
            drop_q <= drop_d;
            derr_q <= derr_d;
        end
    end

    assign o_ERR_DROP = drop_q;
    assign o_ERR_DATA = derr_q;

`else

    assign o_ERR_DROP = 1'b0;
    assign o_ERR_DATA = 1'b0;

`endif

endmodule
